// File: rtl/ifid_hazard_if.sv
// Bundle of decode-stage hazard inputs and pipeline-control outputs shared by
// the IF/ID hazard controller and the pipeline that drives it.
interface ifid_hazard_if;
  logic       id_valid;
  logic [2:0] hazRs_id;
  logic       Rs_hazP_id;
  logic [2:0] hazRt_id;
  logic       Rt_hazP_id;
  logic [2:0] ex_rd;
  logic       ex_wr;
  logic       ex_memrd;
  logic [2:0] mem_rd;
  logic       mem_wr;
  logic       ex_redirect;
  logic       id_halt;

  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halted;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, hazRs_id, Rs_hazP_id, hazRt_id, Rt_hazP_id,
           ex_rd, ex_wr, ex_memrd, mem_rd, mem_wr, ex_redirect, id_halt,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, halted,
           ctrl_state, stall_cnt
  );

  modport slave (
    input  id_valid, hazRs_id, Rs_hazP_id, hazRt_id, Rt_hazP_id,
           ex_rd, ex_wr, ex_memrd, mem_rd, mem_wr, ex_redirect, id_halt,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, halted,
           ctrl_state, stall_cnt
  );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller: stall, bubble, flush and halt sequencing for the
// 16-bit five-stage core. Build option: FORWARD_EN (EX/MEM forwarding present).
module ifid_hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  ifid_hazard_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t      state;
  state_t      nxt_state;
  logic [1:0]  rem;
  logic [1:0]  nxt_rem;
  logic [15:0] stall_cnt_q;
  logic        halted_q;

  logic        match_ex;
  logic        match_mem;
  logic [1:0]  need;

  logic        pc_hold_c;
  logic        ifid_hold_c;
  logic        ifid_flush_c;
  logic        idex_bubble_c;
  logic        haz_stall_c;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic reg_match(
    input logic       valid,
    input logic       rs_p,
    input logic [2:0] rs,
    input logic       rt_p,
    input logic [2:0] rt,
    input logic [2:0] rd
  );
    reg_match = valid & ((rs_p & (rs == rd)) | (rt_p & (rt == rd)));
  endfunction

  assign match_ex  = reg_match(hz.id_valid, hz.Rs_hazP_id, hz.hazRs_id,
                               hz.Rt_hazP_id, hz.hazRt_id, hz.ex_rd);
  assign match_mem = reg_match(hz.id_valid, hz.Rs_hazP_id, hz.hazRs_id,
                               hz.Rt_hazP_id, hz.hazRt_id, hz.mem_rd);

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time; one bubble covers it.
  assign need = (hz.ex_wr & hz.ex_memrd & match_ex) ? 2'd1 : 2'd0;
`else
  // Without forwarding the value is usable once it reaches WB (bypassed to ID).
  assign need = (hz.ex_wr & match_ex)   ? 2'd2 :
                (hz.mem_wr & match_mem) ? 2'd1 : 2'd0;
`endif

  always_comb begin
    nxt_state     = state;
    nxt_rem       = rem;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    haz_stall_c   = 1'b0;
    if (hz.ex_redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      nxt_state     = RUN;
      nxt_rem       = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need != 2'd0) begin
            pc_hold_c     = 1'b1;
            ifid_hold_c   = 1'b1;
            idex_bubble_c = 1'b1;
            haz_stall_c   = 1'b1;
            if (need == 2'd2) begin
              nxt_state = STALL;
              nxt_rem   = 2'd1;
            end
          end else if (hz.id_halt & hz.id_valid) begin
            // HALT itself moves on to ID/EX; the front end is parked behind it.
            pc_hold_c    = 1'b1;
            ifid_flush_c = 1'b1;
            nxt_state    = HALT;
          end
        end
        STALL: begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          haz_stall_c   = 1'b1;
          nxt_rem       = rem - 2'd1;
          if (rem <= 2'd1) begin
            nxt_state = RUN;
            nxt_rem   = 2'd0;
          end
        end
        HALT: begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
        end
        default: begin
          nxt_state = RUN;
          nxt_rem   = 2'd0;
        end
      endcase
    end
  end

  // State / counter boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      rem         <= 2'd0;
      stall_cnt_q <= 16'd0;
      halted_q    <= 1'b0;
    end else begin
      state    <= nxt_state;
      rem      <= nxt_rem;
      halted_q <= (nxt_state == HALT);
      if (haz_stall_c)
        stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  // Reset forces every output low, including the combinational controls.
  assign hz.pc_hold     = rst & pc_hold_c;
  assign hz.ifid_hold   = rst & ifid_hold_c;
  assign hz.ifid_flush  = rst & ifid_flush_c;
  assign hz.idex_bubble = rst & idex_bubble_c;
  assign hz.halted      = rst & halted_q;
  assign hz.ctrl_state  = rst ? state : RUN;
  assign hz.stall_cnt   = rst ? stall_cnt_q : 16'd0;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Self-checking bench for ifid_hazard_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_ifid_hazard_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ifid_hazard_if bus();

  ifid_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: remaining forced stall cycles, parked flag, hazard-cycle count
  int m_left;
  bit m_parked;
  int m_cnt;

  // Expected outputs for the current cycle and the model's next state
  bit e_pc, e_ifh, e_fl, e_bub, e_halted;
  int e_state;
  int n_left;
  bit n_parked;
  int n_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int calc_need();
    bit mx, mm;
    mx = bus.id_valid && ((bus.Rs_hazP_id && bus.hazRs_id == bus.ex_rd) ||
                          (bus.Rt_hazP_id && bus.hazRt_id == bus.ex_rd));
    mm = bus.id_valid && ((bus.Rs_hazP_id && bus.hazRs_id == bus.mem_rd) ||
                          (bus.Rt_hazP_id && bus.hazRt_id == bus.mem_rd));
`ifdef FORWARD_EN
    return (bus.ex_wr && bus.ex_memrd && mx) ? 1 : 0;
`else
    if (bus.ex_wr && mx) return 2;
    if (bus.mem_wr && mm) return 1;
    return 0;
`endif
  endfunction

  task automatic model_eval();
    int nd;
    nd = calc_need();
    e_pc = 0; e_ifh = 0; e_fl = 0; e_bub = 0;
    e_halted = m_parked;
    e_state  = m_parked ? 2 : (m_left > 0 ? 1 : 0);
    n_left = m_left; n_parked = m_parked; n_cnt = m_cnt;
    if (bus.ex_redirect) begin
      e_fl = 1; e_bub = 1; n_left = 0; n_parked = 0;
    end else if (m_parked) begin
      e_pc = 1; e_ifh = 1; e_bub = 1;
    end else if (m_left > 0) begin
      e_pc = 1; e_ifh = 1; e_bub = 1; n_left = m_left - 1;
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (nd > 0) begin
      e_pc = 1; e_ifh = 1; e_bub = 1; n_left = nd - 1;
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (bus.id_halt && bus.id_valid) begin
      e_pc = 1; e_fl = 1; n_parked = 1;
    end
  endtask

  task automatic check_all(input string tag);
    model_eval();
    check({tag, ".pc_hold"},     32'(bus.pc_hold),     32'(e_pc));
    check({tag, ".ifid_hold"},   32'(bus.ifid_hold),   32'(e_ifh));
    check({tag, ".ifid_flush"},  32'(bus.ifid_flush),  32'(e_fl));
    check({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'(e_bub));
    check({tag, ".halted"},      32'(bus.halted),      32'(e_halted));
    check({tag, ".ctrl_state"},  32'(bus.ctrl_state),  32'(e_state));
    check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   32'(m_cnt));
  endtask

  // Inputs are set at the falling edge; check, clock, advance the model.
  task automatic step(input string tag, input bit do_check);
    #1;
    if (do_check) check_all(tag);
    else model_eval();
    @(posedge clk);
    m_left = n_left; m_parked = n_parked; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.hazRs_id = 0; bus.Rs_hazP_id = 0;
    bus.hazRt_id = 0; bus.Rt_hazP_id = 0; bus.ex_rd = 0; bus.ex_wr = 0;
    bus.ex_memrd = 0; bus.mem_rd = 0; bus.mem_wr = 0;
    bus.ex_redirect = 0; bus.id_halt = 0;
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, ".pc_hold"},     32'(bus.pc_hold),     32'd0);
    check({tag, ".ifid_flush"},  32'(bus.ifid_flush),  32'd0);
    check({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'd0);
    check({tag, ".ifid_hold"},   32'(bus.ifid_hold),   32'd0);
    check({tag, ".ctrl_state"},  32'(bus.ctrl_state),  32'd0);
    check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    m_left = 0; m_parked = 0; m_cnt = 0;
    idle_inputs();
    rst = 1'b0;
    // Hazard present while in reset: outputs must still be zero
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 3;
    bus.ex_rd = 3; bus.ex_wr = 1; bus.ex_memrd = 1;
    repeat (3) @(negedge clk);
    #1 check_reset_zero("reset");
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    step("idle", 1);

    // EX-stage producer matches Rs
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 3;
    bus.ex_rd = 3; bus.ex_wr = 1; bus.ex_memrd = 1;
    step("ex_haz_c0", 1);
    step("ex_haz_c1", 1);
    idle_inputs();
    step("ex_haz_done", 1);

    // MEM-stage producer matches Rt
    bus.id_valid = 1; bus.Rt_hazP_id = 1; bus.hazRt_id = 5;
    bus.mem_rd = 5; bus.mem_wr = 1;
    step("mem_haz_c0", 1);
    idle_inputs();
    step("mem_haz_done", 1);

    // ALU producer in EX, then load producer in EX
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 2;
    bus.ex_rd = 2; bus.ex_wr = 1; bus.ex_memrd = 0;
    step("alu_prod", 1);
    step("alu_prod2", 1);
    idle_inputs();
    step("gap", 1);
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 2;
    bus.ex_rd = 2; bus.ex_wr = 1; bus.ex_memrd = 1;
    step("load_prod", 1);
    idle_inputs();
    step("load_prod_done", 1);
    step("load_prod_done2", 1);

    // Redirect arriving in the second cycle of a stall
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 4;
    bus.ex_rd = 4; bus.ex_wr = 1; bus.ex_memrd = 1;
    step("redir_c0", 1);
    idle_inputs();
    bus.ex_redirect = 1;
    step("redir_c1", 1);
    bus.ex_redirect = 0;
    step("redir_after", 1);

    // HALT decode, parked for 10 cycles, released by redirect
    bus.id_valid = 1; bus.id_halt = 1;
    step("halt_dec", 1);
    idle_inputs();
    for (int i = 0; i < 10; i++) step("halt_park", 1);
    bus.ex_redirect = 1;
    step("halt_exit", 1);
    bus.ex_redirect = 0;
    step("halt_after", 1);

    // Stall counter saturation
    bus.id_valid = 1; bus.Rs_hazP_id = 1; bus.hazRs_id = 6;
    bus.ex_rd = 6; bus.ex_wr = 1; bus.ex_memrd = 1;
    for (int i = 0; i < 70000; i++) step("sat", 0);
    step("sat_end", 1);
    check("sat_value", 32'(bus.stall_cnt), 32'hFFFF);

    // Asynchronous reset in the middle of a stall
    step("pre_rst", 1);
    #2 rst = 1'b0;
    #1 check_reset_zero("async_rst");
    check("async_rst.halted", 32'(bus.halted), 32'd0);
    m_left = 0; m_parked = 0; m_cnt = 0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.hazRs_id    = 3'($urandom_range(0, 7));
      bus.Rs_hazP_id  = 1'($urandom_range(0, 1));
      bus.hazRt_id    = 3'($urandom_range(0, 7));
      bus.Rt_hazP_id  = 1'($urandom_range(0, 1));
      bus.ex_rd       = 3'($urandom_range(0, 7));
      bus.ex_wr       = 1'($urandom_range(0, 1));
      bus.ex_memrd    = 1'($urandom_range(0, 1));
      bus.mem_rd      = 3'($urandom_range(0, 7));
      bus.mem_wr      = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 7) == 0);
      bus.id_halt     = ($urandom_range(0, 9) == 0);
      step("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_ctrl.md
# ifid_hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core, sitting beside the fetch/decode pipeline register. It compares the decode-stage source registers and their hazard-present flags against the destinations in ID/EX and EX/MEM, then sequences the machine:
- hold the PC and IF/ID for the required stall count;
- inject a bubble into ID/EX;
- flush IF/ID to NOP (0x0800) on a taken redirect;
- park the front end on HALT.

It also keeps a saturating count of hazard-stall cycles.

## Interface
No parameters; the only build option is the `FORWARD_EN` macro described under Configuration.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction; 0 means a NOP/bubble
- hazRs_id  in  3  decode-stage Rs number
- Rs_hazP_id  in  1  decode instruction reads Rs
- hazRt_id  in  3  decode-stage Rt number
- Rt_hazP_id  in  1  decode instruction reads Rt
- ex_rd  in  3  ID/EX destination register
- ex_wr  in  1  ID/EX instruction writes ex_rd
- ex_memrd  in  1  ID/EX instruction is a load
- mem_rd  in  3  EX/MEM destination register
- mem_wr  in  1  EX/MEM instruction writes mem_rd
- ex_redirect  in  1  branch/jump taken, resolved in EX this cycle
- id_halt  in  1  decode instruction is HALT
- pc_hold  out  1  PC does not update
- ifid_hold  out  1  IF/ID keeps its contents; drives the register's stall input
- ifid_flush  out  1  IF/ID loads 0x0800; overrides ifid_hold
- idex_bubble  out  1  ID/EX loads a bubble: all write and memory enables cleared
- halted  out  1  controller is in HALT
- ctrl_state  out  2  encoding RUN=00, STALL=01, HALT=10
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Matching:
  - match(rd) = id_valid & ((Rs_hazP_id & hazRs_id==rd) | (Rt_hazP_id & hazRt_id==rd)).
  - r0 is an ordinary register; it is not excluded from matching.
- need (stall cycles required, 0–2) is set by the build; see Configuration.
- State register: 2 bits. Countdown register rem: 2 bits.
- RUN:
  - need>0: pc_hold=ifid_hold=idex_bubble=1 in this same cycle.
    - need=2: go to STALL with rem=1.
    - need=1: stay in RUN; the next cycle re-evaluates with the bubble in place.
  - need=0 and id_halt & id_valid: pc_hold=1, ifid_flush=1; HALT passes on to ID/EX. Go to HALT.
  - Otherwise: all control outputs 0.
- STALL:
  - pc_hold=ifid_hold=idex_bubble=1; hazard inputs are ignored.
  - rem decrements each cycle; when rem==1, go to RUN.
- HALT:
  - pc_hold=ifid_hold=1, idex_bubble=1, halted=1.
  - Left only by ex_redirect or by reset.
- ex_redirect:
  - Highest priority, in any state.
  - Asserts ifid_flush=1 and idex_bubble=1, with pc_hold=0 and ifid_hold=0.
  - Next state is RUN and rem is cleared. Any pending stall or halt is aborted.
- stall_cnt:
  - Increments on every cycle where ifid_hold=1 from a hazard (RUN with need>0, or STALL) and ex_redirect=0.
  - Saturates at 0xFFFF.
  - HALT cycles are not counted.

## Timing
- While rst is low: state=RUN, rem=0, stall_cnt=0, and all outputs are forced to 0.
- After reset release, the first clock edge evaluates normally.
- Control outputs are combinational from the current state and inputs: zero-cycle latency from hazard visibility to hold.
- halted and ctrl_state are registered; halted rises the cycle after HALT is decoded.
- Simultaneous events:
  - redirect beats stall;
  - stall beats halt (halt is re-detected after the stall);
  - redirect in HALT exits to RUN.
- Reset asserted mid-STALL: state returns to RUN immediately (asynchronous); the stall is abandoned.

## Configuration
- `FORWARD_EN` defined (EX→EX and MEM→EX forwarding present):
  - need=1 iff ex_wr & ex_memrd & match(ex_rd); otherwise 0.
  - STALL is never entered.
- `FORWARD_EN` undefined (register file bypasses WB→ID; no other forwarding):
  - need=2 if ex_wr & match(ex_rd);
  - else need=1 if mem_wr & match(mem_rd);
  - else 0.

## Test plan
- No forwarding; ex_rd=3, ex_wr=1, decode reads Rs=3 -> hold/bubble for 2 cycles (RUN then STALL) -> back in RUN; stall_cnt=2.
- No forwarding; only mem_rd=5, mem_wr=1 matches Rt=5 -> exactly 1 hold cycle, state stays RUN.
- `FORWARD_EN`; ALU producer ex_rd=2, ex_memrd=0 matches -> no hold. Same with ex_memrd=1 -> 1 hold cycle.
- ex_redirect asserted in the second cycle of a 2-cycle stall -> ifid_flush=1, idex_bubble=1, pc_hold=0 that cycle; state RUN next; stall_cnt=1.
- id_halt & id_valid in RUN -> ifid_flush=1 that cycle; halted=1 next cycle and held for 10 cycles. Then ex_redirect -> halted=0, state RUN.
- Force 70000 consecutive hazard cycles -> stall_cnt=0xFFFF. Then pulse rst low mid-STALL -> all outputs 0 asynchronously and stall_cnt=0.
